// File: rtl/zilla_div_pkg.sv
// Shared definitions for the RV32M divide issue controller: decode constants,
// special-case result constants and the controller state encoding.
package zilla_div_pkg;

  localparam logic [6:0]  OPC_OP        = 7'b0110011;
  localparam logic [6:0]  F7_MULDIV     = 7'b0000001;
  localparam logic [2:0]  F3_DIV        = 3'b100;
  localparam logic [2:0]  F3_DIVU       = 3'b101;
  localparam logic [2:0]  F3_REM        = 3'b110;
  localparam logic [2:0]  F3_REMU       = 3'b111;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } div_state_e;

  // True for DIV/DIVU/REM/REMU: OP major opcode, MULDIV funct7, funct3[2] set.
  function automatic logic is_div_instr(input logic [31:0] instr);
    return (instr[6:0] == OPC_OP) && (instr[31:25] == F7_MULDIV) && instr[14];
  endfunction

endpackage

// File: rtl/zilla_div_special.sv
// Combinational detector for divide cases resolved without the divider:
// divide-by-zero and signed overflow (most-negative / -1), with their results.
module zilla_div_special
  import zilla_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  special_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  // Width-generic forms of DIV_BY_ZERO_Q and INT_MIN.
  localparam logic [DATA_WIDTH-1:0] ALL_ONES_W = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ZERO_W     = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] INT_MIN_W  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed_op_s;
  logic rem_op_s;
  logic div_zero_s;
  logic overflow_s;

  assign signed_op_s = (funct3_i == F3_DIV) || (funct3_i == F3_REM);
  assign rem_op_s    = (funct3_i == F3_REM) || (funct3_i == F3_REMU);
  assign div_zero_s  = (divisor_i == ZERO_W);
  assign overflow_s  = signed_op_s && (dividend_i == INT_MIN_W) && (divisor_i == ALL_ONES_W);
  assign special_o   = div_zero_s || overflow_s;

  // Select the architecturally defined result for the detected special case.
  always_comb begin
    result_o = ZERO_W;
    if (div_zero_s) begin
      result_o = rem_op_s ? dividend_i : ALL_ONES_W;
    end else if (overflow_s) begin
      result_o = rem_op_s ? ZERO_W : INT_MIN_W;
    end else begin
      result_o = ZERO_W;
    end
  end

endmodule

// File: rtl/zilla_div_issue_ctrl.sv
// Execute-stage initiator for the RV32M divider: accepts divide instructions,
// resolves special cases locally, issues the rest to the divider wrapper,
// stalls until the result returns, drains orphaned results after a flush and
// aborts a stuck wait with a watchdog.
module zilla_div_issue_ctrl
  import zilla_div_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] rs1_val_i,
  input  logic [DATA_WIDTH-1:0] rs2_val_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  div_en_o,
  output logic [DATA_WIDTH-1:0] div_dividend_o,
  output logic [DATA_WIDTH-1:0] div_divisor_o,
  output logic [31:0]           div_opcode_o,
  input  logic [DATA_WIDTH-1:0] div_result_i,
  input  logic                  div_valid_i,
  input  logic                  div_busy_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e            state_r;
  div_state_e            next_state_s;
  logic                  is_div_s;
  logic                  special_s;
  logic [DATA_WIDTH-1:0] special_res_s;
  logic                  accept_s;
  logic                  cap_div_s;
  logic                  timeout_s;
  logic                  cnt_last_s;
  logic                  waiting_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0] dividend_r;
  logic [DATA_WIDTH-1:0] divisor_r;
  logic [31:0]           opcode_r;
  logic [4:0]            rd_r;
  logic [DATA_WIDTH-1:0] wb_data_r;
  logic                  wb_valid_r;
  logic                  err_r;

  zilla_div_special #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_special (
    .funct3_i   (instr_i[14:12]),
    .dividend_i (rs1_val_i),
    .divisor_i  (rs2_val_i),
    .special_o  (special_s),
    .result_o   (special_res_s)
  );

  assign is_div_s   = is_div_instr(instr_i);
  assign waiting_s  = (state_r == ST_WAIT) || (state_r == ST_DRAIN);
  assign cnt_last_s = (cnt_r == CNT_LAST);

  // Stall and issue depend on same-cycle flush, so they are decoded directly.
  assign stall_o  = (state_r == ST_ISSUE) || waiting_s ||
                    ((state_r == ST_IDLE) && valid_i && is_div_s && !flush_i);
  assign div_en_o = (state_r == ST_ISSUE) && !flush_i;

  assign div_dividend_o = dividend_r;
  assign div_divisor_o  = divisor_r;
  assign div_opcode_o   = opcode_r;
  assign wb_valid_o     = wb_valid_r;
  assign wb_rd_o        = rd_r;
  assign wb_data_o      = wb_data_r;
  assign err_o          = err_r;

  // Next-state logic with acceptance, result capture and watchdog decisions.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    cap_div_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid_i && is_div_s && !flush_i && !div_busy_i) begin
          accept_s     = 1'b1;
          next_state_s = special_s ? ST_DONE : ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        next_state_s = flush_i ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (div_valid_i && flush_i) begin
          next_state_s = ST_IDLE;
        end else if (div_valid_i) begin
          cap_div_s    = 1'b1;
          next_state_s = ST_DONE;
        end else if (flush_i) begin
          next_state_s = ST_DRAIN;
        end else if (cnt_last_s) begin
          timeout_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (div_valid_i) begin
          next_state_s = ST_IDLE;
        end else if (cnt_last_s) begin
          timeout_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Watchdog counter: cleared entering WAIT/DRAIN, counts every cycle spent there.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (((next_state_s == ST_WAIT) || (next_state_s == ST_DRAIN)) &&
                 (next_state_s != state_r)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (waiting_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Operand/instruction capture at acceptance; held while the divider samples them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dividend_r <= {DATA_WIDTH{1'b0}};
      divisor_r  <= {DATA_WIDTH{1'b0}};
      opcode_r   <= 32'h0000_0000;
      rd_r       <= 5'd0;
    end else if (accept_s) begin
      dividend_r <= rs1_val_i;
      divisor_r  <= rs2_val_i;
      opcode_r   <= instr_i;
      rd_r       <= instr_i[11:7];
    end else begin
      dividend_r <= dividend_r;
      divisor_r  <= divisor_r;
      opcode_r   <= opcode_r;
      rd_r       <= rd_r;
    end
  end

  // Writeback data: local special result at acceptance or divider result in WAIT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_data_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s && special_s) begin
      wb_data_r <= special_res_s;
    end else if (cap_div_s) begin
      wb_data_r <= div_result_i;
    end else begin
      wb_data_r <= wb_data_r;
    end
  end

  // One-cycle writeback-valid and watchdog-error pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_valid_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      wb_valid_r <= (next_state_s == ST_DONE);
      err_r      <= timeout_s;
    end
  end

endmodule

// File: tb/tb_zilla_div_issue_ctrl.sv
// Self-checking bench for zilla_div_issue_ctrl: a timeline model of each
// instruction (latencies derived from the operation rules) sets the expected
// outputs per cycle, a divider model supplies results, and one compare process
// checks every cycle.
module tb_zilla_div_issue_ctrl;
  import zilla_div_pkg::*;

  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [31:0]   instr_i;
  logic [DW-1:0] rs1_val_i;
  logic [DW-1:0] rs2_val_i;
  logic          flush_i;
  logic          stall_o;
  logic          div_en_o;
  logic [DW-1:0] div_dividend_o;
  logic [DW-1:0] div_divisor_o;
  logic [31:0]   div_opcode_o;
  logic [DW-1:0] div_result_i;
  logic          div_valid_i;
  logic          div_busy_i;
  logic          wb_valid_o;
  logic [4:0]    wb_rd_o;
  logic [DW-1:0] wb_data_o;
  logic          err_o;

  zilla_div_issue_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .instr_i(instr_i),
    .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i), .flush_i(flush_i),
    .stall_o(stall_o), .div_en_o(div_en_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_opcode_o(div_opcode_o),
    .div_result_i(div_result_i), .div_valid_i(div_valid_i), .div_busy_i(div_busy_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int wb_cnt = 0;
  logic [31:0] last_wb_data = 32'd0;
  logic [4:0]  last_wb_rd = 5'd0;

  logic        chk_on = 1'b0;
  logic        exp_stall, exp_en, exp_wbv, exp_err;
  logic [31:0] exp_dvd = 32'd0, exp_dvs = 32'd0, exp_opc = 32'd0, exp_wbd = 32'd0;
  logic [4:0]  exp_rd = 5'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    else n_pass++;
  endtask

  // Reference result of a divide instruction from the RV32M rules.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) r = f3[1] ? a : 32'hFFFF_FFFF;
    else if (!f3[0] && a == INT_MIN && b == 32'hFFFF_FFFF) r = f3[1] ? 32'd0 : INT_MIN;
    else begin
      case (f3)
        F3_DIV:  r = 32'(sa / sb);
        F3_DIVU: r = a / b;
        F3_REM:  r = 32'(sa % sb);
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    logic [4:0] r1, r2;
    r1 = 5'($urandom);
    r2 = 5'($urandom);
    return {F7_MULDIV, r2, r1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 3))
      0: return INT_MIN;
      1: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle compare against the model's expectations.
  always @(negedge clk_i) begin
    if (chk_on) begin
      chk("stall_o", stall_o, exp_stall);
      chk("div_en_o", div_en_o, exp_en);
      chk("wb_valid_o", wb_valid_o, exp_wbv);
      chk("err_o", err_o, exp_err);
      chk("div_dividend_o", div_dividend_o, exp_dvd);
      chk("div_divisor_o", div_divisor_o, exp_dvs);
      chk("div_opcode_o", div_opcode_o, exp_opc);
      if (exp_wbv) begin
        chk("wb_data_o", wb_data_o, exp_wbd);
        chk("wb_rd_o", wb_rd_o, exp_rd);
      end
    end
  end

  // Event counters for pulse-count expectations.
  always @(negedge clk_i) begin
    if (div_en_o) en_cnt++;
    if (err_o) err_cnt++;
    if (wb_valid_o) begin
      wb_cnt++;
      last_wb_data = wb_data_o;
      last_wb_rd = wb_rd_o;
    end
  end

  task automatic step(input logic s, input logic e, input logic w, input logic r);
    exp_stall = s;
    exp_en = e;
    exp_wbv = w;
    exp_err = r;
    @(posedge clk_i);
    #1;
  endtask

  // One divide instruction. lat: WAIT cycle (from WAIT entry) of div_valid_i,
  // 0 = never. flush_at: WAIT cycle of a flush, -1 = flush in ISSUE, 0 = none.
  task automatic run_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int busy_n, input int lat,
                        input int flush_at);
    logic [31:0] ins, res;
    bit special, fin, in_drain, dv, fl;
    int k;
    ins = mk_instr(f3, rd);
    res = ref_div(f3, a, b);
    special = (b == 32'd0) || (!f3[0] && a == INT_MIN && b == 32'hFFFF_FFFF);
    instr_i = ins; rs1_val_i = a; rs2_val_i = b; valid_i = 1'b1;
    div_busy_i = 1'b1;
    for (int i = 0; i < busy_n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    div_busy_i = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_dvd = a; exp_dvs = b; exp_opc = ins;
    if (special) begin
      exp_wbd = res; exp_rd = rd;
      flush_i = 1'($urandom_range(0, 1));
      step(1'b0, 1'b0, 1'b1, 1'b0);
      flush_i = 1'b0;
    end else if (flush_at < 0) begin
      flush_i = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      flush_i = 1'b0;
    end else begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      fin = 1'b0; in_drain = 1'b0; k = 0;
      for (int w = 1; w <= 300 && !fin; w++) begin
        k++;
        dv = (lat == w);
        fl = !in_drain && (flush_at == w);
        div_valid_i = dv;
        div_result_i = dv ? res : $urandom;
        flush_i = fl;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        div_valid_i = 1'b0; flush_i = 1'b0;
        if (dv && !in_drain && !fl) begin
          exp_wbd = res; exp_rd = rd;
          flush_i = 1'($urandom_range(0, 1));
          step(1'b0, 1'b0, 1'b1, 1'b0);
          flush_i = 1'b0;
          fin = 1'b1;
        end else if (dv) begin
          fin = 1'b1;
        end else if (fl) begin
          in_drain = 1'b1; k = 0; valid_i = 1'b0;
        end else if (k == TO) begin
          valid_i = 1'b0;
          step(1'b0, 1'b0, 1'b0, 1'b1);
          fin = 1'b1;
        end
      end
    end
    valid_i = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int e0, w0, r0, lat, fa;
    logic [2:0] f3;
    logic [31:0] a, b;
    rst_i = 1'b0; valid_i = 1'b0; instr_i = 32'd0; rs1_val_i = 32'd0; rs2_val_i = 32'd0;
    flush_i = 1'b0; div_result_i = 32'd0; div_valid_i = 1'b0; div_busy_i = 1'b0;
    exp_stall = 1'b0; exp_en = 1'b0; exp_wbv = 1'b0; exp_err = 1'b0;
    #2;
    chk("reset_stall", stall_o, 32'd0);
    chk("reset_wb_valid", wb_valid_o, 32'd0);
    chk("reset_wb_data", wb_data_o, 32'd0);
    chk("reset_opcode", div_opcode_o, 32'd0);
    chk("reset_err", err_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    chk_on = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Model pins.
    chk("model_div_100_7", ref_div(F3_DIV, 32'd100, 32'd7), 32'd14);
    chk("model_remu_100_7", ref_div(F3_REMU, 32'd100, 32'd7), 32'd2);
    chk("model_div_m7_2", ref_div(F3_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem_m7_2", ref_div(F3_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    // Non-divide instructions and a flushed divide are not accepted.
    valid_i = 1'b1; instr_i = {F7_MULDIV, 10'd0, 3'b000, 5'd3, OPC_OP};
    step(1'b0, 1'b0, 1'b0, 1'b0);
    instr_i = {7'b0000000, 10'd0, F3_DIV, 5'd3, OPC_OP};
    step(1'b0, 1'b0, 1'b0, 1'b0);
    instr_i = mk_instr(F3_DIV, 5'd4); rs2_val_i = 32'd3; flush_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b0; valid_i = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // DIV 100/7 with a 33-cycle divider.
    e0 = en_cnt; w0 = wb_cnt;
    run_op(F3_DIV, 5'd5, 32'd100, 32'd7, 0, 33, 0);
    chk("div100_en_pulses", 32'(en_cnt - e0), 32'd1);
    chk("div100_wb_count", 32'(wb_cnt - w0), 32'd1);
    chk("div100_wb_data", last_wb_data, 32'd14);
    chk("div100_wb_rd", 32'(last_wb_rd), 32'd5);

    // Divide by zero.
    e0 = en_cnt;
    run_op(F3_DIVU, 5'd6, 32'd5, 32'd0, 0, 10, 0);
    chk("divu_by0_data", last_wb_data, 32'hFFFF_FFFF);
    run_op(F3_REM, 5'd7, 32'hFFFF_FFF9, 32'd0, 0, 10, 0);
    chk("rem_by0_data", last_wb_data, 32'hFFFF_FFF9);
    chk("by0_no_issue", 32'(en_cnt - e0), 32'd0);

    // Signed overflow.
    e0 = en_cnt;
    run_op(F3_DIV, 5'd8, INT_MIN, 32'hFFFF_FFFF, 0, 10, 0);
    chk("ovf_div_data", last_wb_data, 32'h8000_0000);
    run_op(F3_REM, 5'd9, INT_MIN, 32'hFFFF_FFFF, 0, 10, 0);
    chk("ovf_rem_data", last_wb_data, 32'd0);
    chk("ovf_no_issue", 32'(en_cnt - e0), 32'd0);

    // Flush in WAIT cycle 3, result at 33 drained, then a following DIV.
    w0 = wb_cnt;
    run_op(F3_DIV, 5'd10, 32'd1000, 32'd9, 0, 33, 3);
    chk("drain_no_wb", 32'(wb_cnt - w0), 32'd0);
    run_op(F3_DIV, 5'd11, 32'd1000, 32'd9, 0, 5, 0);
    chk("after_drain_wb", 32'(wb_cnt - w0), 32'd1);
    chk("after_drain_data", last_wb_data, 32'd111);

    // Divider never answers: watchdog.
    w0 = wb_cnt; r0 = err_cnt;
    run_op(F3_DIVU, 5'd12, 32'd77, 32'd3, 0, 0, 0);
    chk("timeout_err_pulses", 32'(err_cnt - r0), 32'd1);
    chk("timeout_no_wb", 32'(wb_cnt - w0), 32'd0);

    // Divider busy for 10 cycles before acceptance.
    w0 = wb_cnt;
    run_op(F3_REMU, 5'd13, 32'd100, 32'd7, 10, 12, 0);
    chk("busy_wb_data", last_wb_data, 32'd2);
    chk("busy_wb_count", 32'(wb_cnt - w0), 32'd1);

    // Reset in the middle of WAIT.
    valid_i = 1'b1; instr_i = mk_instr(F3_DIVU, 5'd14); rs1_val_i = 32'd50; rs2_val_i = 32'd3;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_dvd = 32'd50; exp_dvs = 32'd3; exp_opc = instr_i;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    valid_i = 1'b0; rst_i = 1'b0;
    #1;
    chk("midrst_stall", stall_o, 32'd0);
    chk("midrst_dividend", div_dividend_o, 32'd0);
    chk("midrst_wb_data", wb_data_o, 32'd0);
    chk("midrst_wb_rd", 32'(wb_rd_o), 32'd0);
    exp_dvd = 32'd0; exp_dvs = 32'd0; exp_opc = 32'd0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized instructions.
    for (int n = 0; n < 40; n++) begin
      f3 = 3'd4 + 3'($urandom_range(0, 3));
      a = pick_a();
      b = pick_b();
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      case ($urandom_range(0, 5))
        0: fa = -1;
        1: fa = int'($urandom_range(1, 45));
        default: fa = 0;
      endcase
      run_op(f3, 5'($urandom), a, b, int'($urandom_range(0, 3)), lat, fa);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
